// File: rtl/vector_packer.sv
// Packs VLEN float32 words into one vector, zero-padding short vectors ended by in_last.
// Latency: vec_valid rises on the edge accepting the last element; in_ready follows vec_ready while full.
module vector_packer #(
    parameter int VLEN = 4,
    parameter int CW   = $clog2(VLEN + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          in_data,
    input  logic                 in_valid,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic [32*VLEN-1:0]   vec_data,
    output logic [CW-1:0]        vec_count,
    output logic                 vec_valid,
    input  logic                 vec_ready
);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       idx_q, idx_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [32*VLEN-1:0]  data_q, data_d;
    logic                in_xfer;
    logic                out_xfer;

    // Gating with rst_n keeps in_ready low for the whole reset assertion.
    assign in_ready  = rst_n & ((state_q == FILL) | vec_ready);
    assign vec_valid = (state_q == FULL);
    assign vec_data  = data_q;
    assign vec_count = cnt_q;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = vec_valid & vec_ready;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        case (state_q)
            FILL: begin
                if (in_xfer) begin
                    for (int k = 0; k < VLEN; k++) begin
                        if (idx_q == CW'(k)) begin
                            data_d[32*k +: 32] = in_data;
                        end
                    end
                    idx_d = idx_q + CW'(1);
                    if (idx_q == CW'(VLEN - 1) || in_last) begin
                        state_d = FULL;
                        cnt_d   = idx_q + CW'(1);
                    end
                end
            end
            FULL: begin
                if (out_xfer) begin
                    data_d = '0;
                    if (in_xfer) begin
                        // Pass-through: the departing vector frees the lanes for this element.
                        data_d[31:0] = in_data;
                        idx_d        = CW'(1);
                        if (VLEN == 1 || in_last) begin
                            cnt_d = CW'(1);
                        end else begin
                            state_d = FILL;
                            cnt_d   = '0;
                        end
                    end else begin
                        idx_d   = '0;
                        cnt_d   = '0;
                        state_d = FILL;
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            idx_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_vector_packer.sv
// Randomized and directed bench for vector_packer (VLEN=4 and VLEN=1 instances).
module tb_vector_packer;

    localparam int VLEN = 4;
    localparam int CW   = 3;
    localparam int VW   = 32 * VLEN;
    localparam logic [31:0] FV [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                                       32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
    localparam logic [VW-1:0] V1 = 128'h40800000_40400000_40000000_3F800000;
    localparam logic [VW-1:0] V2 = 128'h41000000_40E00000_40C00000_40A00000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   in_data;
    logic          in_valid, in_last, in_ready;
    logic [VW-1:0] vec_data;
    logic [CW-1:0] vec_count;
    logic          vec_valid, vec_ready;

    logic [31:0]   in1_data, v1_data;
    logic          in1_valid, in1_last, in1_ready, v1_valid, v1_ready;
    logic [0:0]    v1_count;

    int errors = 0;
    int checks = 0;

    // Reference model: a pending complete vector plus the partially assembled one.
    bit            m_have;
    logic [VW-1:0] m_pend;
    int            m_cnt;
    logic [VW-1:0] m_cur;
    int            m_n;
    bit            m1_have;
    logic [31:0]   m1_pend;

    vector_packer #(.VLEN(VLEN), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .vec_data(vec_data), .vec_count(vec_count),
        .vec_valid(vec_valid), .vec_ready(vec_ready)
    );

    vector_packer #(.VLEN(1), .CW(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_data(in1_data), .in_valid(in1_valid), .in_last(in1_last),
        .in_ready(in1_ready), .vec_data(v1_data), .vec_count(v1_count),
        .vec_valid(v1_valid), .vec_ready(v1_ready)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        m_have = 0; m_pend = '0; m_cnt = 0; m_cur = '0; m_n = 0;
        m1_have = 0; m1_pend = '0;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic l, input logic r);
        in_valid = v; in_data = d; in_last = l; vec_ready = r;
        #1;
    endtask

    task automatic tick();
        bit acc, outx;
        @(posedge clk);
        if (!rst_n) begin
            model_clear();
        end else begin
            outx = m_have && vec_ready;
            acc  = in_valid && (!m_have || vec_ready);
            if (outx) m_have = 0;
            if (acc) begin
                m_cur = m_cur | (VW'(in_data) << (32 * m_n));
                m_n++;
                if (m_n == VLEN || in_last) begin
                    m_pend = m_cur; m_cnt = m_n; m_have = 1;
                    m_cur = '0; m_n = 0;
                end
            end
            outx = m1_have && v1_ready;
            acc  = in1_valid && (!m1_have || v1_ready);
            if (outx) m1_have = 0;
            if (acc) begin
                m1_have = 1; m1_pend = in1_data;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%b want=0", in_ready); end
        checks++; if (vec_valid !== 1'b0) begin errors++; $display("FAIL rst_vec_valid got=%b want=0", vec_valid); end
        checks++; if (vec_data !== '0) begin errors++; $display("FAIL rst_vec_data got=%h want=0", vec_data); end
        checks++; if (vec_count !== '0) begin errors++; $display("FAIL rst_vec_count got=%0d want=0", vec_count); end
        @(posedge clk); #3;
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_basic_fill();
        for (int i = 0; i < 4; i++) begin
            drive(1, FV[i], 0, 0);
            checks++; if (in_ready !== 1'b1 || vec_valid !== 1'b0) begin
                errors++; $display("FAIL fill_hs[%0d] got rdy=%b vld=%b want rdy=1 vld=0", i, in_ready, vec_valid);
            end
            tick();
        end
        for (int c = 0; c < 3; c++) begin
            drive(0, 0, 0, 0);
            checks++; if (vec_valid !== 1'b1) begin errors++; $display("FAIL fill_valid got=%b want=1", vec_valid); end
            checks++; if (vec_data !== V1) begin errors++; $display("FAIL fill_data got=%h want=%h", vec_data, V1); end
            checks++; if (vec_count !== 3'd4) begin errors++; $display("FAIL fill_count got=%0d want=4", vec_count); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready got=%b want=0", in_ready); end
            tick();
        end
        drive(0, 0, 0, 1);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_rdy_follow got=%b want=1", in_ready); end
        tick();
        drive(0, 0, 0, 0);
        checks++; if (vec_valid !== 1'b0 || vec_data !== '0 || vec_count !== '0) begin
            errors++; $display("FAIL fill_clear got vld=%b data=%h cnt=%0d want 0/0/0", vec_valid, vec_data, vec_count);
        end
    endtask

    task automatic test_early_last();
        drive(1, 32'h3F800000, 0, 0); tick();
        drive(1, 32'h40000000, 1, 0); tick();
        drive(0, 0, 0, 0);
        checks++; if (vec_valid !== 1'b1) begin errors++; $display("FAIL early_valid got=%b want=1", vec_valid); end
        checks++; if (vec_data !== {64'h0, 32'h40000000, 32'h3F800000}) begin
            errors++; $display("FAIL early_data got=%h want=%h", vec_data, {64'h0, 32'h40000000, 32'h3F800000});
        end
        checks++; if (vec_count !== 3'd2) begin errors++; $display("FAIL early_count got=%0d want=2", vec_count); end
        drive(0, 0, 0, 1); tick();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            drive(1, FV[i], 0, 1);
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d] got=%b want=1", i, in_ready); end
            if (i == 4) begin
                checks++; if (vec_valid !== 1'b1 || vec_data !== V1 || vec_count !== 3'd4) begin
                    errors++; $display("FAIL b2b_vec1 got vld=%b data=%h cnt=%0d want 1/%h/4", vec_valid, vec_data, vec_count, V1);
                end
            end
            if (i == 5) begin
                checks++; if (vec_valid !== 1'b0 || vec_data !== {96'h0, 32'h40A00000} || vec_count !== '0) begin
                    errors++; $display("FAIL b2b_passthru got vld=%b data=%h cnt=%0d want 0/40a00000 in lane0/0", vec_valid, vec_data, vec_count);
                end
            end
            tick();
        end
        drive(0, 0, 0, 1);
        checks++; if (vec_valid !== 1'b1 || vec_data !== V2 || vec_count !== 3'd4) begin
            errors++; $display("FAIL b2b_vec2 got vld=%b data=%h cnt=%0d want 1/%h/4", vec_valid, vec_data, vec_count, V2);
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic [VW-1:0] held;
        logic [31:0]   x;
        for (int i = 0; i < 4; i++) begin
            drive(1, $urandom, 0, 0); tick();
        end
        held = m_pend;
        for (int c = 0; c < 5; c++) begin
            drive(1, $urandom, 0, 0);
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got=%b want=0", c, in_ready); end
            checks++; if (vec_data !== held) begin errors++; $display("FAIL bp_hold[%0d] got=%h want=%h", c, vec_data, held); end
            tick();
        end
        x = $urandom;
        drive(1, x, 0, 1);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got=%b want=1", in_ready); end
        tick();
        drive(0, 0, 0, 0);
        checks++; if (vec_valid !== 1'b0 || vec_data !== {96'h0, x} || vec_count !== '0) begin
            errors++; $display("FAIL bp_first_accept got vld=%b data=%h cnt=%0d want 0/%h/0", vec_valid, vec_data, vec_count, x);
        end
        drive(1, $urandom, 1, 1); tick();
        drive(0, 0, 0, 1); tick();
    endtask

    task automatic test_reset_mid();
        drive(1, 32'h11111111, 0, 0); tick();
        drive(1, 32'h22222222, 0, 0); tick();
        drive(1, 32'h33333333, 0, 0);
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        checks++; if (vec_valid !== 1'b0 || vec_data !== '0 || vec_count !== '0) begin
            errors++; $display("FAIL rmid_outputs got vld=%b data=%h cnt=%0d want 0/0/0", vec_valid, vec_data, vec_count);
        end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rmid_in_ready got=%b want=0", in_ready); end
        tick();
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1, FV[i+4], 0, 0); tick();
        end
        drive(0, 0, 0, 0);
        checks++; if (vec_valid !== 1'b1 || vec_data !== V2 || vec_count !== 3'd4) begin
            errors++; $display("FAIL rmid_fresh got vld=%b data=%h cnt=%0d want 1/%h/4", vec_valid, vec_data, vec_count, V2);
        end
        drive(0, 0, 0, 1); tick();
    endtask

    task automatic test_random();
        logic [VW-1:0] e_data;
        logic [CW-1:0] e_cnt;
        logic          e_rdy;
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 4) == 0, $urandom_range(0, 2) != 0);
            e_data = m_have ? m_pend : m_cur;
            e_cnt  = m_have ? CW'(m_cnt) : '0;
            e_rdy  = !m_have || vec_ready;
            checks++; if (vec_valid !== m_have) begin errors++; $display("FAIL rnd_valid[%0d] got=%b want=%b", n, vec_valid, m_have); end
            checks++; if (in_ready !== e_rdy) begin errors++; $display("FAIL rnd_in_ready[%0d] got=%b want=%b", n, in_ready, e_rdy); end
            checks++; if (vec_data !== e_data) begin errors++; $display("FAIL rnd_data[%0d] got=%h want=%h", n, vec_data, e_data); end
            checks++; if (vec_count !== e_cnt) begin errors++; $display("FAIL rnd_count[%0d] got=%0d want=%0d", n, vec_count, e_cnt); end
            tick();
        end
        drive(0, 0, 0, 1); tick();
    endtask

    task automatic test_vlen1();
        logic [31:0] e_data;
        drive(0, 0, 0, 1);
        in1_valid = 1; in1_data = 32'h7FC00001; in1_last = 0; v1_ready = 0;
        #1;
        checks++; if (in1_ready !== 1'b1 || v1_valid !== 1'b0) begin
            errors++; $display("FAIL v1_idle got rdy=%b vld=%b want 1/0", in1_ready, v1_valid);
        end
        tick();
        in1_valid = 0;
        #1;
        checks++; if (v1_valid !== 1'b1 || v1_data !== 32'h7FC00001 || v1_count !== 1'b1) begin
            errors++; $display("FAIL v1_nan got vld=%b data=%h cnt=%0d want 1/7fc00001/1", v1_valid, v1_data, v1_count);
        end
        for (int n = 0; n < 80; n++) begin
            in1_valid = $urandom_range(0, 3) != 0;
            in1_data  = $urandom;
            in1_last  = $urandom_range(0, 1) != 0;
            v1_ready  = $urandom_range(0, 3) != 0;
            #1;
            e_data = m1_have ? m1_pend : 32'h0;
            checks++; if (v1_valid !== m1_have || in1_ready !== (!m1_have || v1_ready)) begin
                errors++; $display("FAIL v1_hs[%0d] got vld=%b rdy=%b want vld=%b", n, v1_valid, in1_ready, m1_have);
            end
            checks++; if (v1_data !== e_data || v1_count !== 1'(m1_have)) begin
                errors++; $display("FAIL v1_data[%0d] got=%h cnt=%0d want=%h cnt=%0d", n, v1_data, v1_count, e_data, m1_have);
            end
            tick();
        end
    endtask

    initial begin
        in_valid = 0; in_data = '0; in_last = 0; vec_ready = 0;
        in1_valid = 0; in1_data = '0; in1_last = 0; v1_ready = 0;
        model_clear();
        test_reset();
        test_basic_fill();
        test_early_last();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_vlen1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
